spi_target_mem: RTL and testbench
=================================

// Module: spi_target_mem
// PURPOSE
// SPI target (slave) that answers the SPI controller channels of the SPI-RAID engine: a small byte memory
// reached over a 4-wire SPI link. Serves as the on-chip loopback target for RAID bring-up and as the model
// for external disks. Sits on io pads or directly on a controller channel; runs on the system clock, oversamples SCLK/CS.
// PARAMETERS
// DEPTH     16  bytes of storage; power of two, 2..256; address byte uses low log2(DEPTH) bits
// SYNC_STG  2   synchroniser flops on spi_clk/spi_cs/spi_mosi (>=2)
// PORTS
// wb_clk_i    in   1  system clock; single clock domain
// wb_rst_i    in   1  synchronous, active-high reset
// spi_clk     in   1  SCLK from controller, mode 0 (CPOL=0, CPHA=0), <= wb_clk_i/8
// spi_cs      in   1  chip select, active low
// spi_mosi    in   1  controller->target data, MSB first
// spi_miso    out  1  target->controller data, MSB first
// spi_miso_oe out  1  1 = drive miso pad (feeds io_oeb inverted)
// wr_strobe   out  1  one-cycle pulse per committed write byte
// wr_addr     out  8  address of committed byte (zero-extended)
// wr_data     out  8  committed byte
// cmd_err     out  1  one-cycle pulse on unknown opcode
// xfer_done   out  1  one-cycle pulse on CS deassert after >=1 complete byte
// BEHAVIOUR
// - Reset: all outputs 0, memory contents cleared to 0x00, FSM=IDLE, bit counter 0, shift regs 0.
// - Inputs pass SYNC_STG flops; SCLK rise/fall detected from synced history (1-cycle pulses). Edge
//   latency 2-3 clk; reset mid-transfer aborts with no write and forces IDLE.
// - Sample mosi on SCLK rise; update miso on SCLK fall. 3-bit bit counter, wraps every 8 rises.
// - Frame: byte0 opcode, byte1 address, then data bytes; address increments per byte, wraps mod DEPTH.
// - Opcodes: 0x02 WRITE, 0x03 READ; anything else -> cmd_err pulse, state IGNORE.
// - FSM: IDLE -(cs low)-> CMD -(8th rise, op ok)-> ADDR -(8th rise)-> WDATA|RDATA; CMD -(bad op)-> IGNORE.
//   Any state -(synced cs high)-> IDLE, counter cleared, partial byte discarded, never written.
// - WDATA: on 8th rise of each byte, mem[addr]<=byte; wr_strobe/wr_addr/wr_data valid same cycle as
//   write; addr<=addr+1 (wrap). wr_addr/wr_data hold until next strobe.
// - RDATA: on 8th rise of address byte (and of each data byte) load tx shift reg from mem[addr],
//   addr<=addr+1; bit7 appears on spi_miso at following SCLK fall (first-bit valid before next rise).
//   Remaining bits shift out on falls.
// - spi_miso_oe = 1 while synced cs low, else 0; spi_miso = 0 outside RDATA (incl. CMD/ADDR/IGNORE).
// - xfer_done: pulse the cycle cs-high is seen if >=8 rises occurred in the frame; no pulse for
//   cs toggles with fewer bits.
// - cs low with SCLK high at assertion: first rise not counted until SCLK seen low (mode 0 rule).
// STRUCTURE
// - Shared header spi_target_defs.vh: opcode constants OP_WRITE/OP_READ, FSM state encodings.
// - Sub-module spi_sync_edge: SYNC_STG-flop synchroniser + rise/fall pulse outputs; one per SCLK and CS,
//   mosi uses sync only. Memory is a flop array inside spi_target_mem.
// TESTING
// 1 Write: cs low, send 02 05 A5 5A, cs high -> wr_strobe x2 (addr 5 data A5, addr 6 data 5A), xfer_done x1.
// 2 Read: after test 1 send 03 05 + 16 dummy clocks -> miso returns A5 then 5A, oe high whole frame.
// 3 Wrap: write 02 0F 11 22 (DEPTH=16) -> mem[15]=11, mem[0]=22; read 03 0F -> 11 22.
// 4 Bad opcode 9F 00 00 -> cmd_err 1 pulse, miso stays 0, no wr_strobe, xfer_done at cs high.
// 5 Abort: 02 03 then 4 bits of data, cs high -> no write, no stray strobe; next 03 03 reads old value.
// 6 Reset mid-write after 12 bits -> all outputs 0, memory 0x00; following 02 00 7E writes correctly.

Source files
------------

// File: rtl/spi_target_mem_pkg.sv
// spi_target_mem_pkg
// Shared definitions for the SPI target memory: command opcodes and the
// frame-level FSM state encoding used by spi_target_mem.
package spi_target_mem_pkg;

  // Command opcodes carried in the first byte of every frame
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;

  // Frame position: opcode, address, then a run of data bytes
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_target_mem_sync_edge.sv
// spi_target_mem_sync_edge
// Brings one asynchronous SPI pin into the system clock domain through a
// SYNC_STG-deep flop chain and flags its rising and falling edges.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   d     in  asynchronous pin
//   q     out synchronised level
//   rise  out one-cycle pulse when q goes 0->1
//   fall  out one-cycle pulse when q goes 1->0
module spi_target_mem_sync_edge #(
  parameter int   SYNC_STG = 2,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STG-1:0] chain;
  logic                prev;

  // Reset value is the pin's idle level so no edge is reported on release
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {SYNC_STG{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[SYNC_STG-2:0], d};
      prev  <= chain[SYNC_STG-1];
    end
  end

  assign q    = chain[SYNC_STG-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_target_mem.sv
// spi_target_mem
// SPI mode-0 target giving a controller access to a DEPTH-byte memory.
// Frame: opcode (0x02 write / 0x03 read), address, data bytes; the address
// auto-increments and wraps modulo DEPTH. SCLK/CS/MOSI are oversampled on
// the system clock.
// Ports:
//   wb_clk_i     in  system clock
//   wb_rst_i     in  synchronous active-high reset
//   spi_clk      in  SCLK (CPOL=0, CPHA=0)
//   spi_cs       in  chip select, active low
//   spi_mosi     in  controller->target data, MSB first
//   spi_miso     out target->controller data, MSB first
//   spi_miso_oe  out miso pad drive enable (cs asserted)
//   wr_strobe    out one-cycle pulse per committed write byte
//   wr_addr      out address of last committed byte
//   wr_data      out last committed byte
//   cmd_err      out one-cycle pulse on an unknown opcode
//   xfer_done    out one-cycle pulse at cs release after >=1 full byte
module spi_target_mem
  import spi_target_mem_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int SYNC_STG = 2
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       spi_clk,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       cmd_err,
  output logic       xfer_done
);

  localparam int AW = $clog2(DEPTH);

  logic                sclk_q, sclk_rise, sclk_fall;
  logic                cs_q, cs_rise, cs_fall;
  logic [SYNC_STG-1:0] mosi_chain;
  logic                mosi_q;

  state_t              state;
  logic [2:0]          bit_cnt;
  logic [7:0]          rx_shift;
  logic [7:0]          tx_shift;
  logic [7:0]          rx_next;
  logic [AW-1:0]       addr;
  logic                is_read;
  logic                armed;
  logic                byte_seen;
  logic [7:0]          mem [DEPTH];

  spi_target_mem_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b0)) u_sclk_sync (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .d    (spi_clk),
    .q    (sclk_q),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_target_mem_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_cs_sync (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .d    (spi_cs),
    .q    (cs_q),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // MOSI goes through the same depth as SCLK so a detected rise lines up
  // with the data bit the controller held stable across that rise
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mosi_chain <= '0;
    end else begin
      mosi_chain <= {mosi_chain[SYNC_STG-2:0], spi_mosi};
    end
  end

  assign mosi_q  = mosi_chain[SYNC_STG-1];
  assign rx_next = {rx_shift[6:0], mosi_q};

  // Frame FSM, shift registers, memory and all registered outputs.
  // 'armed' blocks counting a rise until SCLK has been seen low inside the
  // frame, so a controller asserting cs with SCLK high does not gain a bit.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      addr        <= '0;
      is_read     <= 1'b0;
      armed       <= 1'b0;
      byte_seen   <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      wr_strobe   <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      cmd_err     <= 1'b0;
      xfer_done   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      wr_strobe   <= 1'b0;
      cmd_err     <= 1'b0;
      xfer_done   <= cs_rise & byte_seen;
      spi_miso_oe <= ~cs_q;

      if (cs_q) begin
        // cs released: drop any partial byte and return to idle
        state     <= ST_IDLE;
        bit_cnt   <= '0;
        rx_shift  <= '0;
        tx_shift  <= '0;
        spi_miso  <= 1'b0;
        armed     <= 1'b0;
        byte_seen <= 1'b0;
      end else if (state == ST_IDLE) begin
        if (cs_fall) begin
          state    <= ST_CMD;
          bit_cnt  <= '0;
          rx_shift <= '0;
          armed    <= ~sclk_q;
        end
      end else begin
        if (sclk_fall) begin
          armed <= 1'b1;
          if (state == ST_RDATA) begin
            spi_miso <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end

        if (sclk_rise && armed) begin
          rx_shift <= rx_next;
          bit_cnt  <= bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) begin
            byte_seen <= 1'b1;
            case (state)
              ST_CMD: begin
                if (rx_next == OP_WRITE) begin
                  is_read <= 1'b0;
                  state   <= ST_ADDR;
                end else if (rx_next == OP_READ) begin
                  is_read <= 1'b1;
                  state   <= ST_ADDR;
                end else begin
                  cmd_err <= 1'b1;
                  state   <= ST_IGNORE;
                end
              end
              ST_ADDR: begin
                if (is_read) begin
                  // Prefetch so bit7 can leave on the very next SCLK fall
                  tx_shift <= mem[rx_next[AW-1:0]];
                  addr     <= rx_next[AW-1:0] + 1'b1;
                  state    <= ST_RDATA;
                end else begin
                  addr  <= rx_next[AW-1:0];
                  state <= ST_WDATA;
                end
              end
              ST_WDATA: begin
                mem[addr] <= rx_next;
                wr_strobe <= 1'b1;
                wr_addr   <= 8'(addr);
                wr_data   <= rx_next;
                addr      <= addr + 1'b1;
              end
              ST_RDATA: begin
                tx_shift <= mem[addr];
                addr     <= addr + 1'b1;
              end
              default: begin
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_target_mem.sv
// tb_spi_target_mem
// Directed bench for spi_target_mem: a table of SPI frames with expected
// MISO bytes, write strobes, cmd_err and xfer_done pulse counts, plus
// hand-written sequences for abort, short cs toggle, reset mid-write and
// cs asserted with SCLK high.
module tb_spi_target_mem;

  localparam time HALF = 100ns;

  typedef struct {
    string       name;
    int          nbits;
    logic [47:0] tx;
    logic [47:0] rx;
    logic [5:0]  rx_chk;
    int          n_wr;
    logic [31:0] wr_exp;
    int          n_err;
    int          n_done;
  } vec_t;

  logic       wb_clk_i;
  logic       wb_rst_i;
  logic       spi_clk;
  logic       spi_cs;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       cmd_err;
  logic       xfer_done;

  int          check_count = 0;
  int          pass_count  = 0;
  int          err_cnt     = 0;
  int          done_cnt    = 0;
  logic [15:0] wr_log [$];
  vec_t        vecs [11];

  spi_target_mem #(.DEPTH(16), .SYNC_STG(2)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .spi_clk     (spi_clk),
    .spi_cs      (spi_cs),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .cmd_err     (cmd_err),
    .xfer_done   (xfer_done)
  );

  // 100 MHz system clock
  initial wb_clk_i = 1'b0;
  always #5ns wb_clk_i = ~wb_clk_i;

  // Pulse outputs are logged on the falling edge, away from the active edge
  always @(negedge wb_clk_i) begin
    if (wr_strobe) wr_log.push_back({wr_addr, wr_data});
    if (cmd_err) err_cnt++;
    if (xfer_done) done_cnt++;
  end

  // Guard against a stuck run
  initial begin
    #500us;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Mode 0 controller: drive MOSI while SCLK low, sample MISO just before rise
  task automatic shiftBits(input logic [47:0] tx, input int nbits, output logic [47:0] rx, output logic oe_ok);
    rx    = '0;
    oe_ok = 1'b1;
    for (int k = 0; k < nbits; k++) begin
      spi_mosi = tx[47-k];
      #(HALF);
      rx[47-k] = spi_miso;
      if (spi_miso_oe !== 1'b1) oe_ok = 1'b0;
      spi_clk = 1'b1;
      #(HALF);
      spi_clk = 1'b0;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [47:0] rx;
    logic        oe_ok;
    int          e0;
    int          d0;
    e0 = err_cnt;
    d0 = done_cnt;
    wr_log.delete();
    spi_cs = 1'b0;
    #(HALF);
    shiftBits(v.tx, v.nbits, rx, oe_ok);
    #(HALF);
    spi_cs = 1'b1;
    #(4*HALF);
    for (int i = 0; i < 6; i++) begin
      if (v.rx_chk[i])
        checkOutput($sformatf("%s miso byte%0d", v.name, i), 32'(rx[47-8*i -: 8]), 32'(v.rx[47-8*i -: 8]));
    end
    checkOutput({v.name, " oe in frame"}, 32'(oe_ok), 32'd1);
    checkOutput({v.name, " oe idle"}, 32'(spi_miso_oe), 32'd0);
    checkOutput({v.name, " n writes"}, 32'(wr_log.size()), 32'(v.n_wr));
    for (int i = 0; i < v.n_wr && i < wr_log.size(); i++) begin
      checkOutput($sformatf("%s write%0d", v.name, i), 32'(wr_log[i]), 32'(v.wr_exp[31-16*i -: 16]));
    end
    checkOutput({v.name, " cmd_err"}, 32'(err_cnt - e0), 32'(v.n_err));
    checkOutput({v.name, " xfer_done"}, 32'(done_cnt - d0), 32'(v.n_done));
  endtask

  initial begin
    logic [47:0] rx;
    logic        oe_ok;
    int          d0;
    int          e0;

    // Byte i of tx/rx sits at [47-8*i -: 8]; rx_chk bit i selects byte i
    vecs[0]  = '{name:"write",      nbits:32, tx:48'h02_05_A5_5A_00_00, rx:48'h0,
                 rx_chk:6'b000000, n_wr:2, wr_exp:32'h05A5_065A, n_err:0, n_done:1};
    vecs[1]  = '{name:"read",       nbits:32, tx:48'h03_05_00_00_00_00, rx:48'h00_00_A5_5A_00_00,
                 rx_chk:6'b001111, n_wr:0, wr_exp:32'h0, n_err:0, n_done:1};
    vecs[2]  = '{name:"wrap write", nbits:32, tx:48'h02_0F_11_22_00_00, rx:48'h0,
                 rx_chk:6'b000000, n_wr:2, wr_exp:32'h0F11_0022, n_err:0, n_done:1};
    vecs[3]  = '{name:"wrap read",  nbits:32, tx:48'h03_0F_00_00_00_00, rx:48'h00_00_11_22_00_00,
                 rx_chk:6'b001111, n_wr:0, wr_exp:32'h0, n_err:0, n_done:1};
    vecs[4]  = '{name:"bad op",     nbits:24, tx:48'h9F_00_00_00_00_00, rx:48'h0,
                 rx_chk:6'b000111, n_wr:0, wr_exp:32'h0, n_err:1, n_done:1};
    vecs[5]  = '{name:"write 3",    nbits:24, tx:48'h02_03_C3_00_00_00, rx:48'h0,
                 rx_chk:6'b000000, n_wr:1, wr_exp:32'h03C3_0000, n_err:0, n_done:1};
    vecs[6]  = '{name:"read run",   nbits:40, tx:48'h03_04_00_00_00_00, rx:48'h00_00_00_A5_5A_00,
                 rx_chk:6'b011111, n_wr:0, wr_exp:32'h0, n_err:0, n_done:1};
    vecs[7]  = '{name:"read after abort", nbits:24, tx:48'h03_03_00_00_00_00, rx:48'h00_00_C3_00_00_00,
                 rx_chk:6'b000100, n_wr:0, wr_exp:32'h0, n_err:0, n_done:1};
    vecs[8]  = '{name:"read cleared", nbits:32, tx:48'h03_05_00_00_00_00, rx:48'h00_00_00_00_00_00,
                 rx_chk:6'b001100, n_wr:0, wr_exp:32'h0, n_err:0, n_done:1};
    vecs[9]  = '{name:"write 7E",   nbits:24, tx:48'h02_00_7E_00_00_00, rx:48'h0,
                 rx_chk:6'b000000, n_wr:1, wr_exp:32'h007E_0000, n_err:0, n_done:1};
    vecs[10] = '{name:"read 7E",    nbits:24, tx:48'h03_00_00_00_00_00, rx:48'h00_00_7E_00_00_00,
                 rx_chk:6'b000100, n_wr:0, wr_exp:32'h0, n_err:0, n_done:1};

    wb_rst_i = 1'b1;
    spi_clk  = 1'b0;
    spi_cs   = 1'b1;
    spi_mosi = 1'b0;
    #2ns;
    #50ns;
    checkOutput("reset miso", 32'(spi_miso), 32'd0);
    checkOutput("reset oe", 32'(spi_miso_oe), 32'd0);
    checkOutput("reset wr_strobe", 32'(wr_strobe), 32'd0);
    checkOutput("reset wr_addr/data", {16'h0, wr_addr, wr_data}, 32'd0);
    checkOutput("reset cmd_err/xfer_done", {30'h0, cmd_err, xfer_done}, 32'd0);
    wb_rst_i = 1'b0;
    #(2*HALF);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Abort: opcode, address, then 4 data bits before cs release
    $display("[TB] abort sequence");
    d0 = done_cnt;
    wr_log.delete();
    spi_cs = 1'b0;
    #(HALF);
    shiftBits(48'h02_03_F0_00_00_00, 20, rx, oe_ok);
    #(HALF);
    spi_cs = 1'b1;
    #(4*HALF);
    checkOutput("abort n writes", 32'(wr_log.size()), 32'd0);
    checkOutput("abort xfer_done", 32'(done_cnt - d0), 32'd1);
    applyStimulus(vecs[7]);

    // Short cs toggle with only 3 bits: no completed byte, no done pulse
    $display("[TB] short frame sequence");
    d0 = done_cnt;
    e0 = err_cnt;
    spi_cs = 1'b0;
    #(HALF);
    shiftBits(48'hFF_00_00_00_00_00, 3, rx, oe_ok);
    #(HALF);
    spi_cs = 1'b1;
    #(4*HALF);
    checkOutput("short xfer_done", 32'(done_cnt - d0), 32'd0);
    checkOutput("short cmd_err", 32'(err_cnt - e0), 32'd0);

    // Reset 12 bits into a write frame
    $display("[TB] reset mid-write sequence");
    wr_log.delete();
    spi_cs = 1'b0;
    #(HALF);
    shiftBits(48'h02_00_7E_00_00_00, 12, rx, oe_ok);
    #(HALF);
    wb_rst_i = 1'b1;
    #30ns;
    checkOutput("midrst miso", 32'(spi_miso), 32'd0);
    checkOutput("midrst oe", 32'(spi_miso_oe), 32'd0);
    checkOutput("midrst wr_addr/data", {16'h0, wr_addr, wr_data}, 32'd0);
    checkOutput("midrst strobe/err/done", {29'h0, wr_strobe, cmd_err, xfer_done}, 32'd0);
    spi_cs = 1'b1;
    #30ns;
    wb_rst_i = 1'b0;
    #(4*HALF);
    checkOutput("midrst n writes", 32'(wr_log.size()), 32'd0);
    for (int i = 8; i < 11; i++) applyStimulus(vecs[i]);

    // cs asserted while SCLK is high: that level must not count as a bit
    $display("[TB] cs with sclk high sequence");
    d0 = done_cnt;
    spi_clk = 1'b1;
    #(HALF);
    spi_cs = 1'b0;
    #(HALF);
    spi_clk = 1'b0;
    shiftBits(48'h03_00_00_00_00_00, 24, rx, oe_ok);
    #(HALF);
    spi_cs = 1'b1;
    #(4*HALF);
    checkOutput("sclk high miso byte2", 32'(rx[31:24]), 32'h7E);
    checkOutput("sclk high xfer_done", 32'(done_cnt - d0), 32'd1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
